// File: rtl/bt_cmd_pkg.sv
// Shared types and constants for the Bluetooth command sequencer: FSM
// states, command source tags, the init command table and button commands.
package bt_cmd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      ISSUE,
      WAIT_RESP,
      IDLE,
      ERR
   } state_t;

   // Which request the in-flight command belongs to
   typedef enum logic [1:0] {
      SRC_INIT,
      SRC_NEXT,
      SRC_PREV
   } cmd_src_t;

   // Command ROM window: start address and length in bytes
   typedef struct packed {
      logic [4:0] start;
      logic [3:0] len;
   } cmd_t;

   localparam int unsigned INIT_CNT = 3;

   localparam cmd_t NEXT_CMD = '{start: 5'd16, len: 4'd4};
   localparam cmd_t PREV_CMD = '{start: 5'd20, len: 4'd4};

   // Power-up init table, issued in index order
   function automatic cmd_t init_cmd(input logic [1:0] idx);
      cmd_t c;
      case (idx)
         2'd0:    c = '{start: 5'd0,  len: 4'd6};
         2'd1:    c = '{start: 5'd6,  len: 4'd5};
         2'd2:    c = '{start: 5'd11, len: 4'd5};
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bt_cmd_seq_btn_edge.sv
// Press detector for one active-low, already debounced button: flags the
// cycle in which the line falls.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   logic btn_q;

   // Previous sample; idles high so leaving reset never looks like a press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_q <= 1'b1;
      else        btn_q <= btn_n;
   end

   assign press = btn_q & ~btn_n;

endmodule

// File: rtl/bt_cmd_seq.sv
// Command sequencer: waits out module power-up, sends the init commands
// with response timeout and bounded retry, then turns next/prev button
// presses into track commands. Retry exhaustion is terminal until reset.
module bt_cmd_seq
   import bt_cmd_pkg::*;
#(
   parameter int unsigned PWR_DLY   = 17'h1FFFF,
   parameter int unsigned RESP_TMO  = 20'hFFFFF,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       next_n,
   input  logic       prev_n,
   input  logic       resp_rcvd,
   output logic       send,
   output logic [4:0] cmd_start,
   output logic [3:0] cmd_len,
   output logic       init_done,
   output logic       err
);

   localparam int unsigned PW = $clog2(PWR_DLY + 1);
   localparam int unsigned TW = $clog2(RESP_TMO + 1);

   localparam logic [PW-1:0] PWR_LAST   = PW'(PWR_DLY - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(RESP_TMO - 1);
   localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRY);
   localparam logic [1:0]    INIT_LAST  = 2'(INIT_CNT - 1);

   state_t        state;
   cmd_src_t      src;
   logic [PW-1:0] pwr_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [1:0]    retry_cnt;
   logic [1:0]    init_idx;

   logic          next_press, prev_press;
   logic          pend_next, pend_prev;
   logic          clr_next, clr_prev;

   btn_edge u_next_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (next_n),
      .press (next_press)
   );

   btn_edge u_prev_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (prev_n),
      .press (prev_press)
   );

   // A pending flag is consumed by the first send of its command only;
   // re-sends after a timeout must not swallow a fresh press.
   assign clr_next = send && (retry_cnt == 2'd0) && (src == SRC_NEXT);
   assign clr_prev = send && (retry_cnt == 2'd0) && (src == SRC_PREV);

   // Pending button requests, captured in every state; a press landing in
   // the clearing cycle wins so it is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_next <= 1'b0;
         pend_prev <= 1'b0;
      end else begin
         pend_next <= (pend_next & ~clr_next) | next_press;
         pend_prev <= (pend_prev & ~clr_prev) | prev_press;
      end
   end

   // Sequencer FSM. Every transition into ISSUE loads the command and the
   // send strobe together, so send and cmd_start/cmd_len line up in the
   // ISSUE cycle. The timeout counter starts at the send cycle, which
   // spaces retries exactly RESP_TMO cycles apart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PWR_WAIT;
         src       <= SRC_INIT;
         pwr_cnt   <= '0;
         tmo_cnt   <= '0;
         retry_cnt <= 2'd0;
         init_idx  <= 2'd0;
         send      <= 1'b0;
         cmd_start <= 5'd0;
         cmd_len   <= 4'd0;
         init_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         send <= 1'b0;
         case (state)
            PWR_WAIT: begin
               if (pwr_cnt == PWR_LAST) begin
                  state                <= ISSUE;
                  src                  <= SRC_INIT;
                  init_idx             <= 2'd0;
                  {cmd_start, cmd_len} <= init_cmd(2'd0);
                  send                 <= 1'b1;
                  tmo_cnt              <= '0;
               end else begin
                  pwr_cnt <= pwr_cnt + 1'b1;
               end
            end

            ISSUE: begin
               // resp_rcvd is deliberately not looked at in the send cycle
               state   <= WAIT_RESP;
               tmo_cnt <= tmo_cnt + 1'b1;
            end

            WAIT_RESP: begin
               if (resp_rcvd) begin
                  retry_cnt <= 2'd0;
                  if (src == SRC_INIT && init_idx != INIT_LAST) begin
                     state                <= ISSUE;
                     init_idx             <= init_idx + 2'd1;
                     {cmd_start, cmd_len} <= init_cmd(init_idx + 2'd1);
                     send                 <= 1'b1;
                     tmo_cnt              <= '0;
                  end else begin
                     if (src == SRC_INIT) init_done <= 1'b1;
                     state <= IDLE;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  if (retry_cnt == RETRY_MAX) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else begin
                     // same command again; cmd_start/cmd_len already hold it
                     state     <= ISSUE;
                     retry_cnt <= retry_cnt + 2'd1;
                     send      <= 1'b1;
                     tmo_cnt   <= '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            IDLE: begin
               if (pend_next) begin
                  state                <= ISSUE;
                  src                  <= SRC_NEXT;
                  {cmd_start, cmd_len} <= NEXT_CMD;
                  send                 <= 1'b1;
                  tmo_cnt              <= '0;
               end else if (pend_prev) begin
                  state                <= ISSUE;
                  src                  <= SRC_PREV;
                  {cmd_start, cmd_len} <= PREV_CMD;
                  send                 <= 1'b1;
                  tmo_cnt              <= '0;
               end
            end

            ERR: begin
               err <= 1'b1;
            end

            default: begin
               state <= PWR_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bt_cmd_seq.sv
// Bench for bt_cmd_seq: a responder plays the command sender, an
// event-timed reference model predicts each send, init_done and err, and
// directed scenarios pin the model with hand-computed send cycles.
module tb_bt_cmd_seq;

   localparam int PWR_DLY   = 16;
   localparam int RESP_TMO  = 64;
   localparam int MAX_RETRY = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       next_n = 1'b1;
   logic       prev_n = 1'b1;
   logic       resp_rcvd = 1'b0;
   logic       send;
   logic [4:0] cmd_start;
   logic [3:0] cmd_len;
   logic       init_done;
   logic       err;

   bt_cmd_seq #(
      .PWR_DLY   (PWR_DLY),
      .RESP_TMO  (RESP_TMO),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .next_n    (next_n),
      .prev_n    (prev_n),
      .resp_rcvd (resp_rcvd),
      .send      (send),
      .cmd_start (cmd_start),
      .cmd_len   (cmd_len),
      .init_done (init_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // cycles elapsed since rst_n was released
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Responder: answers resp_dly cycles after a send unless told to stay silent
   int resp_dly = 10;
   int silent_first = 0;
   bit silent_all = 1'b0;
   int resp_at = -1;
   int nsend = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         resp_at = -1;
         nsend   = 0;
      end else if (send) begin
         if (!silent_all && nsend >= silent_first) resp_at = cyc + resp_dly;
         nsend++;
      end
   end

   always @(posedge clk) begin
      #1;
      resp_rcvd = rst_n && (cyc == resp_at);
   end

   // Reference model: expected {start,len} for the init table
   function automatic logic [8:0] init_ref(input int i);
      case (i)
         0:       return {5'd0, 4'd6};
         1:       return {5'd6, 4'd5};
         default: return {5'd11, 4'd5};
      endcase
   endfunction

   localparam logic [8:0] NEXT_REF = {5'd16, 4'd4};
   localparam logic [8:0] PREV_REF = {5'd20, 4'd4};

   int         m_next, m_sent, m_idx, m_try, m_kind;
   bit         m_wait, m_idle, m_done, m_err, m_pn, m_pp, m_prevn, m_prevp;
   logic [8:0] m_cmd, m_last;
   bit         exp_send;

   int         log_cyc[$];
   int         log_cmd[$];

   // Compare process: DUT outputs against the model on every cycle, then
   // advance the model using this cycle's inputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_send", send, 0);
         chk("rst_cmd", {cmd_start, cmd_len}, 0);
         chk("rst_init_done", init_done, 0);
         chk("rst_err", err, 0);
         m_next = PWR_DLY; m_cmd = init_ref(0); m_last = '0;
         m_kind = 0; m_idx = 0; m_try = 0; m_sent = -1;
         m_wait = 0; m_idle = 0; m_done = 0; m_err = 0;
         m_pn = 0; m_pp = 0; m_prevn = 1; m_prevp = 1;
         log_cyc.delete();
         log_cmd.delete();
      end else begin
         exp_send = (cyc == m_next);
         chk("send", send, exp_send);
         chk("cmd", {cmd_start, cmd_len}, exp_send ? m_cmd : m_last);
         chk("init_done", init_done, m_done);
         chk("err", err, m_err);
         if (send) begin
            log_cyc.push_back(cyc);
            log_cmd.push_back({cmd_start, cmd_len});
         end
         if (exp_send) begin
            m_last = m_cmd; m_sent = cyc; m_wait = 1; m_next = -1;
            if (m_try == 0 && m_kind == 1) m_pn = 0;
            if (m_try == 0 && m_kind == 2) m_pp = 0;
         end else if (m_wait) begin
            if (resp_rcvd) begin
               m_wait = 0; m_try = 0;
               if (m_kind == 0 && m_idx < 2) begin
                  m_idx++; m_cmd = init_ref(m_idx); m_next = cyc + 1;
               end else begin
                  if (m_kind == 0) m_done = 1;
                  m_idle = 1;
               end
            end else if (cyc - m_sent == RESP_TMO - 1) begin
               m_wait = 0;
               if (m_try == MAX_RETRY) m_err = 1;
               else begin m_try++; m_next = cyc + 1; end
            end
         end else if (m_idle) begin
            if (m_pn) begin
               m_cmd = NEXT_REF; m_kind = 1; m_next = cyc + 1; m_idle = 0;
            end else if (m_pp) begin
               m_cmd = PREV_REF; m_kind = 2; m_next = cyc + 1; m_idle = 0;
            end
         end
         if (m_prevn && !next_n) m_pn = 1;
         if (m_prevp && !prev_n) m_pp = 1;
         m_prevn = next_n;
         m_prevp = prev_n;
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic cfg(input int dly, input int sil_first, input bit sil_all);
      resp_dly = dly; silent_first = sil_first; silent_all = sil_all;
   endtask

   task automatic press(input bit nx, input bit pv, input int at);
      wait_cyc(at);
      if (nx) next_n = 1'b0;
      if (pv) prev_n = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      next_n = 1'b1;
      prev_n = 1'b1;
   endtask

   // Hand-computed send log entry: i-th send at cycle c carrying cmd
   task automatic lit(input string nm, input int i, input int c, input int cmd);
      if (i < log_cyc.size()) begin
         chk({nm, "_cycle"}, log_cyc[i], c);
         chk({nm, "_cmd"}, log_cmd[i], cmd);
      end else begin
         chk({nm, "_present"}, log_cyc.size(), i + 1);
      end
   endtask

   initial begin
      // normal init: responses 10 cycles after each send
      cfg(10, 0, 0); do_reset(); wait_cyc(60);
      chk("s1_nsend", log_cyc.size(), 3);
      lit("s1_send0", 0, 16, {5'd0, 4'd6});
      lit("s1_send1", 1, 27, {5'd6, 4'd5});
      lit("s1_send2", 2, 38, {5'd11, 4'd5});
      chk("s1_init_done", init_done, 1);
      chk("s1_err", err, 0);

      // first send unanswered: one retry exactly RESP_TMO later
      cfg(10, 1, 0); do_reset(); wait_cyc(120);
      lit("s2_send0", 0, 16, {5'd0, 4'd6});
      lit("s2_retry", 1, 80, {5'd0, 4'd6});
      lit("s2_send2", 2, 91, {5'd6, 4'd5});
      lit("s2_send3", 3, 102, {5'd11, 4'd5});
      chk("s2_init_done", init_done, 1);

      // never answered: 4 sends then err; a press afterwards is ignored
      cfg(10, 0, 1); do_reset(); wait_cyc(275);
      chk("s3_nsend", log_cyc.size(), 4);
      lit("s3_send3", 3, 208, {5'd0, 4'd6});
      chk("s3_err", err, 1);
      press(1, 0, 280); wait_cyc(330);
      chk("s3_nsend_after_press", log_cyc.size(), 4);
      chk("s3_init_done", init_done, 0);

      // next pressed while init index 1 is outstanding
      cfg(10, 0, 0); do_reset(); press(1, 0, 30); wait_cyc(100);
      chk("s4_nsend", log_cyc.size(), 4);
      lit("s4_next", 3, 50, {5'd16, 4'd4});

      // next and prev in the same cycle while idle
      cfg(10, 0, 0); do_reset(); press(1, 1, 70); wait_cyc(120);
      chk("s5_nsend", log_cyc.size(), 5);
      lit("s5_next", 3, 72, {5'd16, 4'd4});
      lit("s5_prev", 4, 84, {5'd20, 4'd4});

      // response in the timeout cycle wins: no retries
      cfg(63, 0, 0); do_reset(); wait_cyc(210);
      chk("s6_nsend", log_cyc.size(), 3);
      lit("s6_send1", 1, 80, {5'd6, 4'd5});
      lit("s6_send2", 2, 144, {5'd11, 4'd5});
      chk("s6_init_done", init_done, 1);

      // asynchronous reset in the middle of WAIT_RESP
      cfg(10, 0, 0); do_reset(); wait_cyc(40);
      chk("s7_pre_cmd", {cmd_start, cmd_len}, {5'd11, 4'd5});
      #2 rst_n = 1'b0;
      #1;
      chk("s7_async_send", send, 0);
      chk("s7_async_cmd", {cmd_start, cmd_len}, 0);
      chk("s7_async_done", init_done, 0);
      chk("s7_async_err", err, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      wait_cyc(60);
      lit("s7_restart", 0, 16, {5'd0, 4'd6});
      chk("s7_init_done", init_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
